// File: rtl/stochastic_sampler.sv
// Bernoulli sampler: each accepted probability is compared with the same-cycle random
// word, and NUNITS resulting bits are packed into a vector handed off with valid/ready.
module stochastic_sampler #(
    parameter int BITN   = 8,
    parameter int NUNITS = 8,
    parameter int CNTW   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BITN-1:0]   rvalue,
    input  logic [BITN-1:0]   prob,
    input  logic              prob_valid,
    output logic              prob_ready,
    input  logic              flush,
    output logic [NUNITS-1:0] sample_out,
    output logic [CNTW-1:0]   ones_count,
    output logic              sample_valid,
    input  logic              sample_ready
);
    localparam int IDXW = $clog2(NUNITS);
    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] HOLD    = 1'b1;

    logic [0:0]        state_reg, state_next;
    logic [IDXW-1:0]   idx_reg, idx_next;
    logic [NUNITS-1:0] sample_reg, sample_next;
    logic [CNTW-1:0]   count_reg, count_next;
    logic [NUNITS-1:0] sample_upd;
    logic              drawn_bit;

    // Strict compare: rvalue == prob yields 0, so prob = 0 can never fire.
    assign drawn_bit = (rvalue < prob);

    // The drawn bit lands in the slot addressed by idx; other slots keep their value.
    genvar gi;
    generate
        for (gi = 0; gi < NUNITS; gi++) begin : g_slot
            assign sample_upd[gi] = (idx_reg == IDXW'(gi)) ? drawn_bit : sample_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        sample_next = sample_reg;
        count_next  = count_reg;
        case (state_reg)
            COLLECT: begin
                if (flush) begin
                    idx_next    = '0;
                    sample_next = '0;
                    count_next  = '0;
                end else if (prob_valid) begin
                    sample_next = sample_upd;
                    count_next  = count_reg + CNTW'(drawn_bit);
                    if (idx_reg == IDXW'(NUNITS - 1)) begin
                        idx_next   = '0;
                        state_next = HOLD;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            default: begin
                // A completed vector is never discarded: flush is ignored here.
                if (sample_ready) begin
                    state_next  = COLLECT;
                    sample_next = '0;
                    count_next  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= COLLECT;
            idx_reg    <= '0;
            sample_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            sample_reg <= sample_next;
            count_reg  <= count_next;
        end
    end

    assign prob_ready   = (state_reg == COLLECT);
    assign sample_valid = (state_reg == HOLD);
    assign sample_out   = sample_reg;
    assign ones_count   = count_reg;
endmodule

// File: tb/tb_stochastic_sampler.sv
// Directed and statistical checks of stochastic_sampler with BITN=8, NUNITS=8.
`ifndef TB_SEED
`define TB_SEED 1
`endif
module tb_stochastic_sampler;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rvalue;
    logic [7:0] prob;
    logic       prob_valid;
    logic       prob_ready;
    logic       flush;
    logic [7:0] sample_out;
    logic [3:0] ones_count;
    logic       sample_valid;
    logic       sample_ready;

    int n_checks = 0;
    int n_fail   = 0;

    stochastic_sampler #(.BITN(8), .NUNITS(8), .CNTW(4)) dut (
        .clk(clk), .reset(reset), .rvalue(rvalue), .prob(prob),
        .prob_valid(prob_valid), .prob_ready(prob_ready), .flush(flush),
        .sample_out(sample_out), .ones_count(ones_count),
        .sample_valid(sample_valid), .sample_ready(sample_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] prob;
        logic [7:0] rvalue;
        logic [7:0] exp_sample;
        logic [3:0] exp_count;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] s, input logic [3:0] c,
                              input logic v, input logic r);
        check({tag, ".sample_out"}, 32'(sample_out), 32'(s));
        check({tag, ".ones_count"}, 32'(ones_count), 32'(c));
        check({tag, ".sample_valid"}, 32'(sample_valid), 32'(v));
        check({tag, ".prob_ready"}, 32'(prob_ready), 32'(r));
    endtask

    task automatic accept_one(input logic [7:0] p, input logic [7:0] r);
        prob = p; rvalue = r; prob_valid = 1'b1;
        @(negedge clk);
        prob_valid = 1'b0;
    endtask

    initial begin
        int total_ones;
        int model_ones;
        int nvec;
        void'($urandom(`TB_SEED));
        vecs[0] = '{8'd0,   8'd0,   8'h00, 4'd0, 1'b0};
        vecs[1] = '{8'd255, 8'd254, 8'h02, 4'd1, 1'b0};
        vecs[2] = '{8'd128, 8'd128, 8'h02, 4'd1, 1'b0};
        vecs[3] = '{8'd129, 8'd128, 8'h0A, 4'd2, 1'b0};
        vecs[4] = '{8'd255, 8'd255, 8'h0A, 4'd2, 1'b0};
        vecs[5] = '{8'd1,   8'd0,   8'h2A, 4'd3, 1'b0};
        vecs[6] = '{8'd64,  8'd100, 8'h2A, 4'd3, 1'b0};
        vecs[7] = '{8'd200, 8'd10,  8'hAA, 4'd4, 1'b1};

        reset = 1'b0; rvalue = '0; prob = '0; prob_valid = 1'b0;
        flush = 1'b0; sample_ready = 1'b0;

        // Reset held low, then idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outs("in_reset", 8'h00, 4'd0, 1'b0, 1'b1);
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_outs("idle", 8'h00, 4'd0, 1'b0, 1'b1);
        end
        $display("reset/idle done");

        // Deterministic compare table
        for (int i = 0; i < 8; i++) begin
            prob = vecs[i].prob; rvalue = vecs[i].rvalue; prob_valid = 1'b1;
            @(negedge clk);
            check_outs("table", vecs[i].exp_sample, vecs[i].exp_count, vecs[i].exp_valid,
                       !vecs[i].exp_valid);
            $display("accept %0d prob=%0d rvalue=%0d sample_out=%b ones=%0d valid=%0b",
                     i, vecs[i].prob, vecs[i].rvalue, sample_out, ones_count, sample_valid);
        end

        // Backpressure: HOLD must not consume units
        prob = 8'd255; rvalue = 8'd0; prob_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_outs("backpressure", 8'hAA, 4'd4, 1'b1, 1'b0);
        end
        prob_valid = 1'b0; sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        check_outs("release", 8'h00, 4'd0, 1'b0, 1'b1);
        $display("backpressure release sample_out=%b valid=%0b", sample_out, sample_valid);

        // Flush after 5 accepts, colliding with a 6th prob
        for (int i = 0; i < 5; i++) accept_one(8'd255, 8'd0);
        check_outs("pre_flush", 8'h1F, 4'd5, 1'b0, 1'b1);
        prob = 8'd255; rvalue = 8'd0; prob_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; prob_valid = 1'b0;
        check_outs("flush", 8'h00, 4'd0, 1'b0, 1'b1);
        $display("flush in COLLECT sample_out=%b ones=%0d", sample_out, ones_count);
        for (int i = 0; i < 8; i++) begin
            accept_one((i % 2 == 0) ? 8'd255 : 8'd0, 8'd0);
            if (i == 6) check("post_flush.7th_valid", 32'(sample_valid), 32'd0);
        end
        check_outs("post_flush_vec", 8'h55, 4'd4, 1'b1, 1'b0);

        // Flush during HOLD is ignored
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outs("hold_flush", 8'h55, 4'd4, 1'b1, 1'b0);
        end
        flush = 1'b0; sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        check_outs("hold_flush_emit", 8'h00, 4'd0, 1'b0, 1'b1);
        $display("flush in HOLD ignored, vector emitted");

        // Asynchronous reset mid-vector
        for (int i = 0; i < 3; i++) accept_one(8'd255, 8'd0);
        check_outs("pre_reset", 8'h07, 4'd3, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1 check_outs("async_reset", 8'h00, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_outs("post_reset", 8'h00, 4'd0, 1'b0, 1'b1);
        end
        $display("mid-vector reset cleared, no vector emitted");

        // Statistical run with prob = 1/2
        total_ones = 0; model_ones = 0; nvec = 0;
        prob = 8'd128; sample_ready = 1'b1;
        for (int cyc = 0; cyc < 2000 && nvec < 64; cyc++) begin
            rvalue = 8'($urandom_range(0, 255));
            prob_valid = 1'b1;
            if (prob_ready && rvalue < 8'd128) model_ones++;
            @(negedge clk);
            if (sample_valid) begin
                check("stat.popcount", 32'(ones_count), 32'($countones(sample_out)));
                total_ones += int'(ones_count);
                nvec++;
            end
        end
        prob_valid = 1'b0; sample_ready = 1'b0;
        check("stat.vectors", 32'(nvec), 32'd64);
        check("stat.model_total", 32'(total_ones), 32'(model_ones));
        check("stat.in_range", 32'((total_ones >= 216) && (total_ones <= 296)), 32'd1);
        $display("statistical: %0d vectors, %0d ones", nvec, total_ones);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stochastic_sampler.md
# stochastic_sampler

Stochastic binarization stage of the RBM datapath, sitting directly downstream of RandomGenerator. Each accepted unit probability is compared against the RandomGenerator output of the same cycle to draw a Bernoulli sample. NUNITS samples are packed into one vector and handed to the next layer with a valid/ready handshake. A population count of the vector accompanies it.

## Interface
Parameters:
- BITN, 8: probability and random word width. Must equal `BITN` in config.v.
- NUNITS, 8: samples per output vector, range 2..32.
- CNTW, 4: ones-count width, ≥ clog2(NUNITS+1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; every register cleared while low.
- rvalue  in  BITN  random word from RandomGenerator dataOut; new value each cycle.
- prob  in  BITN  unit probability as an unsigned fraction prob/2^BITN.
- prob_valid  in  1  prob is valid.
- prob_ready  out  1  block accepts prob this cycle.
- flush  in  1  synchronous; discards any partial vector.
- sample_out  out  NUNITS  packed samples; first accepted unit is bit 0.
- ones_count  out  CNTW  number of 1s in sample_out.
- sample_valid  out  1  sample_out and ones_count are valid.
- sample_ready  in  1  consumer accepts the vector.

## Operation
- FSM has two states, COLLECT and HOLD. Reset state is COLLECT.
- Reset values:
  - sample_out = 0, ones_count = 0, sample_valid = 0.
  - Internal index idx = 0.
  - prob_ready = 1 once reset is released.
- COLLECT:
  - prob_ready = 1, sample_valid = 0.
  - Accept occurs when prob_valid && prob_ready.
  - On accept, bit = (rvalue < prob), an unsigned strict compare using the rvalue present in that same cycle.
  - The bit is written to sample_out[idx]; ones_count increments by bit; idx increments.
  - Accept with idx == NUNITS-1 moves the FSM to HOLD and sets idx to 0.
- HOLD:
  - prob_ready = 0, sample_valid = 1.
  - sample_out and ones_count stay stable until the consumer accepts.
  - On sample_valid && sample_ready, go to COLLECT and clear sample_out and ones_count in the same edge.
- Probability extremes:
  - prob = 0 always gives bit 0.
  - prob = 2^BITN-1 gives bit 1 unless rvalue = 2^BITN-1.
  - rvalue == prob gives bit 0.
- ones_count saturation is impossible by construction; CNTW is sized to hold NUNITS.
- flush:
  - In COLLECT, flush clears idx, sample_out and ones_count. flush takes priority over a simultaneous accept, and that prob is dropped.
  - In HOLD, flush is ignored; a completed vector is never discarded.
- Reset asserted mid-vector or mid-HOLD clears the partial or held vector immediately; it is not emitted.
- prob is sampled only on accept. prob_valid during HOLD is ignored; the producer must hold prob.

## Timing
- Sample latency is 0: the bit appears in sample_out at the accept edge.
- sample_valid rises on the edge of the NUNITS-th accept and is visible in the following cycle.
- Best-case throughput is one vector per NUNITS+1 cycles, with one HOLD bubble when sample_ready is already high.
- prob_ready depends only on state (registered), with no combinational path from sample_ready.
- While sample_ready is low, HOLD lasts indefinitely and outputs stay stable.
- Asynchronous reset takes effect without a clock edge. Release is synchronous to the first rising edge after reset goes high.

## Test plan
- Reset and idle:
  - Stimulus: hold reset low 3 cycles, then release with prob_valid = 0 for 10 cycles.
  - Required: sample_out = 0, ones_count = 0, sample_valid = 0, prob_ready = 1 throughout.
- Deterministic compare (BITN=8, NUNITS=8, bench drives rvalue directly):
  - Stimulus: eight accepts with (prob, rvalue) = (0,0), (255,254), (128,128), (129,128), (255,255), (1,0), (64,100), (200,10).
  - Required: sample_out = 8'b1010_1010, ones_count = 4, sample_valid high the cycle after the 8th accept.
- Backpressure:
  - Stimulus: sample_ready = 0 for 20 cycles after a full vector, prob_valid held high.
  - Required: prob_ready = 0, outputs unchanged, no unit consumed.
  - Then raise sample_ready for 1 cycle. Required: COLLECT next cycle with sample_out = 0.
- Flush:
  - Stimulus: flush after 5 accepts, asserted together with a 6th valid prob.
  - Required: idx and sample_out cleared, the 6th prob dropped, and the next vector takes exactly 8 further accepts.
  - Stimulus: flush during HOLD. Required: vector still emitted.
- Reset mid-operation:
  - Stimulus: assert reset after 3 accepts, between clock edges.
  - Required: outputs clear asynchronously, and no sample_valid pulse follows release.
- Statistical (RandomGenerator connected, `TB_SEED`):
  - Stimulus: prob = 128 for 64 vectors.
  - Required: total ones across all vectors within 256 ± 40.
